// File: rtl/mac_tile_sched_pkg.sv
// Shared constants, mode encodings and sequencer states for the 16x16 MAC tile.
// The MAC array imports NUM_COLS/COL_W from here as well.
package mac_tile_sched_pkg;

    localparam int unsigned NUM_COLS = 16;
    localparam int unsigned COL_W    = $clog2(NUM_COLS);
    localparam int unsigned KSTEP_W  = 8;
    localparam int unsigned ADDR_W   = 12;

    localparam logic [1:0] MODE_INT8     = 2'b00;
    localparam logic [1:0] MODE_INT4     = 2'b01;
    localparam logic [1:0] MODE_INT4_VSQ = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ISSUE,
        ST_WAIT_LAST,
        ST_DRAIN,
        ST_DONE
    } state_t;

    function automatic logic mode_legal(input logic [1:0] mode);
        return (mode == MODE_INT8) || (mode == MODE_INT4) || (mode == MODE_INT4_VSQ);
    endfunction

endpackage

// File: rtl/mac_tile_sched_if.sv
// Config, operand-buffer, MAC-array and writeback signals of the tile sequencer.
// master = sequencer side, slave = surrounding datapath/control.
interface mac_tile_sched_if #(
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned KSTEP_W  = 8,
    parameter int unsigned ADDR_W   = 12
);
    localparam int unsigned COL_W = $clog2(NUM_COLS);

    logic               cfg_valid;
    logic               cfg_ready;
    logic [KSTEP_W-1:0] cfg_k_steps;
    logic [1:0]         cfg_mode;
    logic               buf_rd_en;
    logic               buf_gnt;
    logic [ADDR_W-1:0]  buf_addr_a;
    logic [ADDR_W-1:0]  buf_addr_b;
    logic               mac_en;
    logic [COL_W-1:0]   mac_col;
    logic               mac_clear;
    logic               is_int8_mode;
    logic               is_int4_mode;
    logic               is_vsq;
    logic               out_valid;
    logic               out_ready;
    logic [COL_W-1:0]   out_col;
    logic               busy;
    logic               done;
    logic               err_cfg;

    modport master (
        input  cfg_valid, cfg_k_steps, cfg_mode, buf_gnt, out_ready,
        output cfg_ready, buf_rd_en, buf_addr_a, buf_addr_b, mac_en, mac_col, mac_clear,
               is_int8_mode, is_int4_mode, is_vsq, out_valid, out_col, busy, done, err_cfg
    );

    modport slave (
        output cfg_valid, cfg_k_steps, cfg_mode, buf_gnt, out_ready,
        input  cfg_ready, buf_rd_en, buf_addr_a, buf_addr_b, mac_en, mac_col, mac_clear,
               is_int8_mode, is_int4_mode, is_vsq, out_valid, out_col, busy, done, err_cfg
    );

endinterface

// File: rtl/mac_tile_addr_gen.sv
// k/col walk for one tile job: advances on each granted read, flags the final
// (k_steps-1, NUM_COLS-1) request and forms the A/B operand-buffer addresses.
module mac_tile_addr_gen #(
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned KSTEP_W  = 8,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       load,
    input  logic [KSTEP_W-1:0]         k_steps,
    input  logic                       adv,
    output logic [KSTEP_W-1:0]         k,
    output logic [$clog2(NUM_COLS)-1:0] col,
    output logic                       last,
    output logic [ADDR_W-1:0]          addr_a,
    output logic [ADDR_W-1:0]          addr_b
);
    localparam int unsigned COL_W = $clog2(NUM_COLS);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COLS - 1);

    logic [KSTEP_W-1:0] k_steps_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            k_steps_q <= '0;
            k         <= '0;
            col       <= '0;
        end else if (load) begin
            k_steps_q <= k_steps;
            k         <= '0;
            col       <= '0;
        end else if (adv) begin
            col <= col + 1'b1;
            if (col == COL_MAX)
                k <= k + 1'b1;
        end
    end

    assign last = (k == k_steps_q - 1'b1) && (col == COL_MAX);

    // NUM_COLS is a power of two, so k*NUM_COLS + col is a shift plus insert; wraps at ADDR_W
    assign addr_a = ADDR_W'(k);
    assign addr_b = (ADDR_W'(k) << COL_W) + ADDR_W'(col);

endmodule

// File: rtl/mac_tile_sched.sv
// Tile sequencer: accepts a job, issues K x NUM_COLS operand reads with MAC
// strobes one cycle later, then drains NUM_COLS accumulator columns to writeback.
module mac_tile_sched #(
    parameter int unsigned NUM_COLS = 16,
    parameter int unsigned KSTEP_W  = 8,
    parameter int unsigned ADDR_W   = 12
) (
    input  logic            clk,
    input  logic            rst,
    mac_tile_sched_if.master bus
);
    localparam int unsigned COL_W = $clog2(NUM_COLS);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COLS - 1);

    import mac_tile_sched_pkg::*;

    state_t             state, nxt;
    logic [1:0]         mode_q;
    logic [KSTEP_W-1:0] k;
    logic [COL_W-1:0]   col;
    logic               last;
    logic [ADDR_W-1:0]  addr_a, addr_b;
    logic               cfg_fire, cfg_ok, rd_fire, out_fire;

    assign cfg_fire = (state == ST_IDLE) && bus.cfg_valid;
    assign cfg_ok   = (bus.cfg_k_steps != '0) && mode_legal(bus.cfg_mode);
    assign rd_fire  = (state == ST_ISSUE) && bus.buf_gnt;
    assign out_fire = (state == ST_DRAIN) && bus.out_ready;

    mac_tile_addr_gen #(
        .NUM_COLS(NUM_COLS),
        .KSTEP_W (KSTEP_W),
        .ADDR_W  (ADDR_W)
    ) u_addr_gen (
        .clk    (clk),
        .rst    (rst),
        .load   (cfg_fire && cfg_ok),
        .k_steps(bus.cfg_k_steps),
        .adv    (rd_fire),
        .k      (k),
        .col    (col),
        .last   (last),
        .addr_a (addr_a),
        .addr_b (addr_b)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= nxt;
    end

    always_comb begin
        nxt           = state;
        bus.cfg_ready = 1'b0;
        bus.buf_rd_en = 1'b0;
        bus.out_valid = 1'b0;
        bus.done      = 1'b0;
        case (state)
            ST_IDLE: begin
                bus.cfg_ready = 1'b1;
                if (bus.cfg_valid && cfg_ok)
                    nxt = ST_ISSUE;
            end
            ST_ISSUE: begin
                bus.buf_rd_en = 1'b1;
                if (bus.buf_gnt && last)
                    nxt = ST_WAIT_LAST;
            end
            ST_WAIT_LAST: nxt = ST_DRAIN;
            ST_DRAIN: begin
                bus.out_valid = 1'b1;
                if (bus.out_ready && (bus.out_col == COL_MAX))
                    nxt = ST_DONE;
            end
            ST_DONE: begin
                bus.done = 1'b1;
                nxt      = ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    // MAC strobes mirror the granted read one cycle later (fixed buffer latency)
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_q        <= '0;
            bus.mac_en    <= 1'b0;
            bus.mac_col   <= '0;
            bus.mac_clear <= 1'b0;
            bus.err_cfg   <= 1'b0;
            bus.out_col   <= '0;
        end else begin
            bus.mac_en    <= rd_fire;
            bus.mac_clear <= rd_fire && (k == '0);
            bus.err_cfg   <= cfg_fire && !cfg_ok;
            if (rd_fire)
                bus.mac_col <= col;
            if (cfg_fire && cfg_ok)
                mode_q <= bus.cfg_mode;
            if (state == ST_WAIT_LAST)
                bus.out_col <= '0;
            else if (out_fire)
                bus.out_col <= bus.out_col + 1'b1;
        end
    end

    assign bus.busy         = (state != ST_IDLE);
    assign bus.is_int8_mode = bus.busy && (mode_q == MODE_INT8);
    assign bus.is_int4_mode = bus.busy && ((mode_q == MODE_INT4) || (mode_q == MODE_INT4_VSQ));
    assign bus.is_vsq       = bus.busy && (mode_q == MODE_INT4_VSQ);
    assign bus.buf_addr_a   = (state == ST_ISSUE) ? addr_a : '0;
    assign bus.buf_addr_b   = (state == ST_ISSUE) ? addr_b : '0;

endmodule

// File: tb/tb_mac_tile_sched.sv
// Self-checking bench for mac_tile_sched: job table, randomized jobs and
// hand-written reset / back-to-back sequences against a read/MAC/drain model.
module tb_mac_tile_sched;
    localparam int NC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mac_tile_sched_if #(.NUM_COLS(16), .KSTEP_W(8), .ADDR_W(12)) bus ();

    mac_tile_sched #(.NUM_COLS(16), .KSTEP_W(8), .ADDR_W(12)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        int         k;
        logic [1:0] mode;
        bit         err;
        bit         e8, e4, ev;
        int         gm;   // 0 grant always, 1 toggle, 2 random
        int         rm;   // 0 ready always, 1 random, 3 stall 5 cycles at col 3
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic any_out();
        return |{bus.buf_rd_en, bus.buf_addr_a, bus.buf_addr_b, bus.mac_en, bus.mac_col,
                 bus.mac_clear, bus.is_int8_mode, bus.is_int4_mode, bus.is_vsq,
                 bus.out_valid, bus.out_col, bus.busy, bus.done, bus.err_cfg};
    endfunction

    task automatic run_err(input int k, input logic [1:0] mode);
        chk("err_idle_ready", 32'(bus.cfg_ready), 1);
        bus.cfg_valid = 1'b1; bus.cfg_k_steps = 8'(k); bus.cfg_mode = mode;
        @(posedge clk); #1;
        bus.cfg_valid = 1'b0;
        chk("err_pulse", 32'(bus.err_cfg), 1);
        chk("err_busy", 32'(bus.busy), 0);
        chk("err_rd_en", 32'(bus.buf_rd_en), 0);
        @(posedge clk); #1;
        chk("err_pulse_end", 32'(bus.err_cfg), 0);
        chk("err_still_idle", 32'(bus.cfg_ready), 1);
        chk("err_no_rd", 32'(bus.buf_rd_en), 0);
    endtask

    task automatic run_job(input int k, input logic [1:0] mode, input bit e8, input bit e4,
                           input bit ev, input int gm, input int rm, input bit hold);
        int cyc, ri, mi, di, stall, done_cyc;
        bit prev_fire, fire, g, r, mode_bad, drain_on;
        chk("job_idle_ready", 32'(bus.cfg_ready), 1);
        chk("job_idle_busy", 32'(bus.busy), 0);
        bus.cfg_valid = 1'b1; bus.cfg_k_steps = 8'(k); bus.cfg_mode = mode;
        @(posedge clk); #1;
        bus.cfg_valid = hold;
        cyc = 2; ri = 0; mi = 0; di = 0; stall = 0; done_cyc = 0;
        prev_fire = 0; mode_bad = 0; drain_on = 0;
        repeat (k * NC * 20 + 200) begin
            chk("mac_en_lag", 32'(bus.mac_en), 32'(prev_fire));
            if (bus.mac_en) begin
                chk("mac_col", 32'(bus.mac_col), 32'(mi % NC));
                chk("mac_clear", 32'(bus.mac_clear), 32'(mi < NC));
                mi++;
            end
            if ({bus.is_int8_mode, bus.is_int4_mode, bus.is_vsq} !== {e8, e4, ev})
                mode_bad = 1;
            if (bus.done) begin
                done_cyc = cyc;
                chk("done_cfg_ready", 32'(bus.cfg_ready), 0);
                break;
            end
            if (gm == 0) g = 1;
            else if (gm == 1) g = (cyc % 2 == 0);
            else g = 1'($urandom_range(0, 1));
            bus.buf_gnt = g;
            fire = 0;
            if (bus.buf_rd_en) begin
                chk("rd_within_job", 32'(ri < k * NC), 1);
                chk("addr_a", 32'(bus.buf_addr_a), 32'(ri / NC));
                chk("addr_b", 32'(bus.buf_addr_b), 32'(ri % 4096));
                if (g) begin fire = 1; ri++; end
            end
            prev_fire = fire;
            if (rm == 0) r = 1;
            else if (rm == 1) r = 1'($urandom_range(0, 1));
            else if (di == 3 && stall < 5) begin r = 0; stall++; end
            else r = 1;
            bus.out_ready = r;
            if (drain_on && di < NC)
                chk("out_valid_hold", 32'(bus.out_valid), 1);
            if (bus.out_valid) begin
                drain_on = 1;
                chk("drain_after_reads", 32'(ri), 32'(k * NC));
                chk("out_col", 32'(bus.out_col), 32'(di));
                if (r) di++;
            end
            @(posedge clk); #1;
            cyc++;
        end
        chk("done_seen", 32'(done_cyc != 0), 1);
        chk("reads_total", 32'(ri), 32'(k * NC));
        chk("macs_total", 32'(mi), 32'(k * NC));
        chk("drain_total", 32'(di), 32'(NC));
        chk("mode_decode", 32'(mode_bad), 0);
        if (gm == 0 && rm == 0)
            chk("done_cycle", 32'(done_cyc), 32'(k * NC + NC + 3));
        if (rm == 3)
            chk("stall_cycles", 32'(stall), 5);
        bus.buf_gnt = 1'b0; bus.out_ready = 1'b0;
        @(posedge clk); #1;
        chk("done_one_cycle", 32'(bus.done), 0);
        chk("back_to_idle", 32'(bus.busy), 0);
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[7];
        int k;
        logic [1:0] m;
        bit found, bad;

        bus.cfg_valid = 0; bus.cfg_k_steps = '0; bus.cfg_mode = '0;
        bus.buf_gnt = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_outputs_zero", 32'(any_out()), 0);
        chk("reset_cfg_ready", 32'(bus.cfg_ready), 1);
        rst = 1'b0;
        @(posedge clk); #1;

        vecs[0] = '{2,   2'b00, 0, 1, 0, 0, 0, 0};
        vecs[1] = '{1,   2'b10, 0, 0, 1, 1, 1, 0};
        vecs[2] = '{1,   2'b01, 0, 0, 1, 0, 0, 3};
        vecs[3] = '{0,   2'b00, 1, 0, 0, 0, 0, 0};
        vecs[4] = '{3,   2'b11, 1, 0, 0, 0, 0, 0};
        vecs[5] = '{3,   2'b01, 0, 0, 1, 0, 2, 1};
        vecs[6] = '{255, 2'b00, 0, 1, 0, 0, 0, 1};
        for (int i = 0; i < 7; i++) begin
            if (vecs[i].err) run_err(vecs[i].k, vecs[i].mode);
            else run_job(vecs[i].k, vecs[i].mode, vecs[i].e8, vecs[i].e4, vecs[i].ev,
                         vecs[i].gm, vecs[i].rm, 0);
        end

        for (int i = 0; i < 10; i++) begin
            k = ($urandom_range(0, 4) == 0) ? 0 : int'($urandom_range(1, 6));
            m = 2'($urandom_range(0, 3));
            if (k == 0 || m == 2'b11) run_err(k, m);
            else run_job(k, m, m == 2'b00, m != 2'b00, m == 2'b10, 2, 1, 0);
        end

        // cfg_valid held across both jobs: second must start on the first IDLE cycle
        run_job(2, 2'b01, 0, 1, 0, 0, 0, 1);
        run_job(1, 2'b00, 1, 0, 0, 0, 0, 0);

        // abort mid-issue at k=1, col=5
        bus.cfg_valid = 1; bus.cfg_k_steps = 8'd3; bus.cfg_mode = 2'b01;
        @(posedge clk); #1;
        bus.cfg_valid = 0; bus.buf_gnt = 1; bus.out_ready = 1;
        found = 0;
        for (int i = 0; i < 40; i++) begin
            if (bus.buf_rd_en && bus.buf_addr_b == 12'd21) begin found = 1; break; end
            @(posedge clk); #1;
        end
        chk("rst_reach_k1c5", 32'(found), 1);
        chk("rst_addr_a_k1", 32'(bus.buf_addr_a), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("midjob_rst_outputs_zero", 32'(any_out()), 0);
        chk("midjob_rst_cfg_ready", 32'(bus.cfg_ready), 1);
        rst = 1'b0;
        bad = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (bus.buf_rd_en || bus.done || bus.busy || bus.mac_en) bad = 1;
        end
        chk("post_rst_quiet", 32'(bad), 0);
        bus.buf_gnt = 0; bus.out_ready = 0;
        run_job(1, 2'b10, 0, 1, 1, 2, 1, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mac_tile_sched.md
Name: mac_tile_sched

Overview:
- Sequencer for the 16x16 int8/int4 MAC array.
- Accepts one tile job (K-step count plus precision mode) over a valid/ready config handshake.
- Walks K steps x 16 output columns, issuing operand-buffer reads and per-column MAC strobes with accumulator-clear on the first K step.
- Then drains the 16 accumulated columns to the writeback stage under valid/ready back-pressure.
- Sits between the command decoder and the MAC array / operand buffers.

Parameters:
NUM_COLS, 16, output columns per tile (power of two; COL_W = log2(NUM_COLS))
KSTEP_W, 8, width of K-step count
ADDR_W, 12, operand-buffer address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
cfg_valid  in  1  job request
cfg_ready  out  1  high only in IDLE
cfg_k_steps  in  KSTEP_W  number of K chunks, 1..2^KSTEP_W-1
cfg_mode  in  2  00 int8, 01 int4, 10 int4+vsq, 11 illegal
buf_rd_en  out  1  operand read request
buf_gnt  in  1  read accepted this cycle (combinational grant from buffer arbiter)
buf_addr_a  out  ADDR_W  A-row address = k
buf_addr_b  out  ADDR_W  B address = k*NUM_COLS + col
mac_en  out  1  operand data valid at array this cycle
mac_col  out  COL_W  column being accumulated
mac_clear  out  1  start column from zero (k==0) instead of stored partial sum
is_int8_mode, is_int4_mode, is_vsq  out  1 each  decoded latched mode
out_valid  out  1  drain column available
out_ready  in  1  writeback accepts
out_col  out  COL_W  column index being drained
busy  out  1  state != IDLE
done  out  1  one-cycle pulse at job completion
err_cfg  out  1  one-cycle pulse on rejected job

Behaviour:
- Reset: every output 0, except cfg_ready, which is 1 once out of reset (IDLE). Counters k and col are 0, latched mode is 0. Reset mid-job aborts immediately; no done pulse is issued.
- States: IDLE, ISSUE, WAIT_LAST, DRAIN, DONE.
- IDLE: on cfg_valid&&cfg_ready:
  - If cfg_k_steps==0 or cfg_mode==11: err_cfg pulses next cycle and the block stays IDLE.
  - Otherwise latch k_steps and mode, set k=0, col=0, and go to ISSUE.
- Mode outputs decode from the latched mode and stay stable until return to IDLE:
  - 00 -> int8=1.
  - 01 -> int4=1.
  - 10 -> int4=1, vsq=1.
- ISSUE:
  - buf_rd_en=1 with the addresses for the current (k, col).
  - Counters advance only when buf_gnt=1. Col increments; on col wrap to 0, k increments.
  - The read accepted at (k_steps-1, NUM_COLS-1) moves the block to WAIT_LAST.
  - No buf_rd_en is ever issued outside ISSUE.
- Read latency is fixed at 1 cycle. For each accepted read, the cycle after shows mac_en=1, with mac_col and mac_clear(=k==0) registered from the accepted request. Gaps from buf_gnt=0 produce mac_en=0 bubbles.
- WAIT_LAST: one cycle so the final mac_en completes, then DRAIN with out_col=0.
- DRAIN:
  - out_valid=1.
  - On out_valid&&out_ready, out_col increments. Acceptance at out_col==NUM_COLS-1 moves to DONE.
  - out_valid may not drop and out_col may not change while out_ready=0.
- DONE: done=1 for exactly one cycle, then IDLE. cfg_ready returns to 1 in IDLE.
- Throughput: K*NUM_COLS + 1 + NUM_COLS + 1 cycles minimum with continuous grant and ready.
- cfg_valid outside IDLE is ignored (cfg_ready=0). cfg_valid in the DONE cycle is not accepted.
- Address arithmetic is truncated to ADDR_W (wraps modulo 2^ADDR_W). k*NUM_COLS is computed as a shift.

Decomposition:
- Shared package holds:
  - mode encodings MODE_INT8=2'b00, MODE_INT4=2'b01, MODE_INT4_VSQ=2'b10;
  - state encoding;
  - NUM_COLS/COL_W constants, which the MAC array also uses.
- One natural sub-module, mac_tile_addr_gen: the k/col counter pair with grant-gated advance, last-flag and address outputs. The FSM, mode decode and drain counter stay in the top module.

Test Plan:
- Reset mid-ISSUE (k=1, col=5), assert rst -> next edge all outputs 0, cfg_ready=1, no done, no further buf_rd_en.
- int8 job, K=2, buf_gnt and out_ready tied 1:
  - 32 consecutive buf_rd_en; addr_b runs 0..31; addr_a is 0 for the first 16 and 1 for the next 16.
  - mac_clear=1 on the first 16 mac_en only; mac_en lags rd_en by 1.
  - 16 out_valid beats, out_col 0..15; done pulses at cycle 51 after accept.
- K=1, mode 10, buf_gnt toggling 1,0,1,0 -> exactly 16 mac_en pulses with bubbles in between; mac_col sequence 0..15; is_int4_mode=is_vsq=1 throughout, is_int8_mode=0.
- DRAIN with out_ready held 0 for 5 cycles at out_col=3 -> out_valid stays 1 and out_col stays 3; resumes at 4 after ready.
- cfg_k_steps=0, then cfg_mode=11 -> err_cfg pulses once each, busy stays 0, no buf_rd_en.
- Back-to-back jobs with cfg_valid held high -> second job accepted on the first IDLE cycle after done; no overlap of buf_rd_en with the first job's drain.
